// File: rtl/idma_read_port_scheduler_if.sv
// Meta and datapath handshake bundle between the iDMA read backend and its AXI/OBI read ports.
// The slave modport is the scheduler's view; the master modport is the surrounding logic's view.
interface idma_read_port_scheduler_if #(
  parameter int unsigned NumAxiPorts = 2
);
  localparam int unsigned IdWidth = $clog2(NumAxiPorts + 1);

  logic                     ar_valid_i;
  logic                     ar_ready_o;
  logic                     ar_src_axi_i;
  logic [NumAxiPorts-1:0]   axi_ar_valid_o;
  logic [NumAxiPorts-1:0]   axi_ar_ready_i;
  logic                     obi_ar_valid_o;
  logic                     obi_ar_ready_i;
  logic                     r_dp_valid_i;
  logic                     r_dp_ready_o;
  logic [NumAxiPorts:0]     r_dp_valid_o;
  logic [NumAxiPorts:0]     r_dp_ready_i;
  logic [IdWidth-1:0]       sel_o;
  logic                     sel_valid_o;
  logic                     busy_o;

  modport slave (
    input  ar_valid_i, ar_src_axi_i, axi_ar_ready_i, obi_ar_ready_i,
    input  r_dp_valid_i, r_dp_ready_i,
    output ar_ready_o, axi_ar_valid_o, obi_ar_valid_o,
    output r_dp_ready_o, r_dp_valid_o, sel_o, sel_valid_o, busy_o
  );

  modport master (
    output ar_valid_i, ar_src_axi_i, axi_ar_ready_i, obi_ar_ready_i,
    output r_dp_valid_i, r_dp_ready_i,
    input  ar_ready_o, axi_ar_valid_o, obi_ar_valid_o,
    input  r_dp_ready_o, r_dp_valid_o, sel_o, sel_valid_o, busy_o
  );
endinterface

// File: rtl/idma_read_port_scheduler.sv
// Routes read meta requests round-robin over AXI ports (or to OBI) and replays the grant order on the datapath.
// Meta path is combinational; a granted ID reaches sel_o one cycle later; a full order FIFO stalls ar_ready_o.
module idma_read_port_scheduler #(
  parameter int unsigned NumAxiPorts = 2,
  parameter int unsigned OrderDepth  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  idma_read_port_scheduler_if.slave bus
);
  localparam int unsigned IdWidth  = $clog2(NumAxiPorts + 1);
  localparam int unsigned PtrWidth = $clog2(OrderDepth);
  localparam int unsigned CntWidth = $clog2(OrderDepth + 1);
  localparam int unsigned RrWidth  = (NumAxiPorts > 1) ? $clog2(NumAxiPorts) : 1;

  typedef logic [IdWidth-1:0] id_t;

  id_t                 order_q [OrderDepth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic [RrWidth-1:0]  rr_q;

  logic                   not_full, not_empty;
  logic                   grant_found;
  logic [RrWidth-1:0]     grant_idx, cand, rr_next;
  logic                   push, pop;
  id_t                    head_id, push_id;
  logic [NumAxiPorts-1:0] axi_valid;
  logic [NumAxiPorts:0]   r_dp_valid;

  assign not_full  = (count_q != CntWidth'(OrderDepth));
  assign not_empty = (count_q != '0);
  assign head_id   = order_q[rd_ptr_q];

  // First ready AXI port at or after the round-robin pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NumAxiPorts; i++) begin
      cand = RrWidth'((32'(rr_q) + i) % NumAxiPorts);
      if (!grant_found && bus.axi_ar_ready_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign rr_next = RrWidth'((32'(grant_idx) + 1) % NumAxiPorts);
  assign push_id = bus.ar_src_axi_i ? IdWidth'(grant_idx) : IdWidth'(NumAxiPorts);

  // Only count gates the meta side, so datapath pops never feed back into ar_ready_o.
  assign bus.ar_ready_o     = not_full & (bus.ar_src_axi_i ? grant_found : bus.obi_ar_ready_i);
  assign bus.obi_ar_valid_o = bus.ar_valid_i & ~bus.ar_src_axi_i & not_full;

  always_comb begin
    axi_valid = '0;
    if (bus.ar_valid_i && bus.ar_src_axi_i && not_full && grant_found) begin
      axi_valid[grant_idx] = 1'b1;
    end
  end
  assign bus.axi_ar_valid_o = axi_valid;

  always_comb begin
    r_dp_valid = '0;
    if (not_empty) begin
      r_dp_valid[head_id] = bus.r_dp_valid_i;
    end
  end
  assign bus.r_dp_valid_o = r_dp_valid;
  assign bus.r_dp_ready_o = not_empty & bus.r_dp_ready_i[head_id];

  assign push = bus.ar_valid_i & bus.ar_ready_o;
  assign pop  = bus.r_dp_valid_i & bus.r_dp_ready_o;

  assign bus.sel_o       = not_empty ? head_id : '0;
  assign bus.sel_valid_o = not_empty;
  assign bus.busy_o      = not_empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      order_q[wr_ptr_q] <= push_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntWidth'(1);
      end
      if (push && bus.ar_src_axi_i) begin
        rr_q <= rr_next;
      end
    end
  end

  // A stalled meta request must keep its source protocol until accepted.
  src_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.ar_valid_i && !bus.ar_ready_o) |=>
      (!bus.ar_valid_i || (bus.ar_src_axi_i == $past(bus.ar_src_axi_i))));
endmodule
